// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register-file writeback bundle, memory-stage bundle,
// load encodings and writeback-stage FSM states.
package pipeline;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } writeback_signals;

    typedef struct packed {
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] result;
        logic            is_load;
        logic [2:0]      funct3;
        logic [1:0]      byte_off;
    } memory_signals;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic {
        StIdle,
        StLoadWait
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data alignment: picks the addressed byte/halfword from a naturally
// aligned read word and sign- or zero-extends it to XLEN.
module load_extend
    import pipeline::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        // Halfword lane depends only on byte_off[1]; misalignment is handled upstream.
        half_sel = word[{byte_off[1], 4'b0000} +: 16];
        data     = word;
        case (funct3)
            LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake, waits (bounded) for
// load data, and emits a one-cycle register-file write request.
module wb_stage
    import pipeline::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  memory_signals    signals_in,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output writeback_signals signals_out,
    output logic             load_err
);

    localparam int unsigned CntW = $clog2(LOAD_TIMEOUT + 1);

    wb_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    writeback_signals out_q, out_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  ext_data;

    load_extend u_load_extend (
        .word     (dmem_rdata),
        .funct3   (funct3_q),
        .byte_off (off_q),
        .data     (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        out_d     = '0;
        err_d     = err_q;
        mem_ready = (state_q == StIdle);
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    if (signals_in.is_load) begin
                        rd_d     = signals_in.rd_addr;
                        funct3_d = signals_in.funct3;
                        off_d    = signals_in.byte_off;
                        cnt_d    = '0;
                        state_d  = StLoadWait;
                    end else begin
                        out_d.rd_addr = signals_in.rd_addr;
                        out_d.data    = signals_in.result;
                    end
                end
            end
            StLoadWait: begin
                // A response in the final wait cycle still beats the timeout.
                if (dmem_rvalid) begin
                    out_d.rd_addr = rd_q;
                    out_d.data    = ext_data;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(LOAD_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign signals_out = out_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed load-extension table, hand-written
// timeout/reset/throughput sequences and a randomized transaction-level model.
module tb_wb_stage;
    import pipeline::*;

    localparam int unsigned T = 4;

    logic             clk;
    logic             rst_n;
    logic             mem_valid;
    logic             mem_ready;
    memory_signals    signals_in;
    logic             dmem_rvalid;
    logic [XLEN-1:0]  dmem_rdata;
    writeback_signals signals_out;
    logic             load_err;

    int   n_pass;
    int   n_total;
    logic err_exp;

    wb_stage #(.LOAD_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .signals_in  (signals_in),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .signals_out (signals_out),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } vec_t;

    // Behavioural extension computed with shifts and masks.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        int unsigned b;
        int unsigned h;
        int unsigned o;
        o = int'(off);
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic memory_signals mk(input logic [4:0] rd, input logic [31:0] res,
                                         input logic ld, input logic [2:0] f3,
                                         input logic [1:0] off);
        memory_signals s;
        s.rd_addr  = rd;
        s.result   = res;
        s.is_load  = ld;
        s.funct3   = f3;
        s.byte_off = off;
        return s;
    endfunction

    task automatic cmp(input string name, input logic [4:0] erd, input logic [31:0] ed,
                       input logic erdy, input logic eerr);
        n_total++;
        if (signals_out.rd_addr === erd && signals_out.data === ed && mem_ready === erdy &&
            load_err === eerr) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rd=%0d data=%h ready=%b err=%b, want rd=%0d data=%h ready=%b err=%b",
                     name, signals_out.rd_addr, signals_out.data, mem_ready, load_err,
                     erd, ed, erdy, eerr);
        end
    endtask

    task automatic drive(input logic v, input memory_signals s, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        mem_valid   = v;
        signals_in  = s;
        dmem_rvalid = rv;
        dmem_rdata  = rd;
    endtask

    task automatic check(input string name, input logic [4:0] erd, input logic [31:0] ed,
                         input logic erdy, input logic eerr);
        @(posedge clk);
        #1;
        cmp(name, erd, ed, erdy, eerr);
    endtask

    task automatic do_alu(input string name, input logic [4:0] rd, input logic [31:0] res,
                          input logic stray);
        drive(1'b1, mk(rd, res, 1'b0, 3'($urandom), 2'($urandom)), stray, $urandom);
        check(name, rd, res, 1'b1, err_exp);
    endtask

    // d = wait cycle index carrying rvalid; d >= T means no response (timeout).
    task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input int d, input logic [31:0] rdata);
        drive(1'b1, mk(rd, $urandom, 1'b1, f3, off), 1'b0, '0);
        check(name, 5'd0, 32'd0, 1'b0, err_exp);
        for (int k = 0; k < int'(T); k++) begin
            if (k == d) begin
                drive(1'b0, '0, 1'b1, rdata);
                check(name, rd, ref_ext(rdata, f3, off), 1'b1, err_exp);
                return;
            end
            drive(1'b0, '0, 1'b0, '0);
            if (k == int'(T) - 1) begin
                err_exp = 1'b1;
                check(name, 5'd0, 32'd0, 1'b1, 1'b1);
            end else begin
                check(name, 5'd0, 32'd0, 1'b0, err_exp);
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        n_pass      = 0;
        n_total     = 0;
        err_exp     = 1'b0;
        rst_n       = 1'b0;
        mem_valid   = 1'b0;
        signals_in  = '0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;

        vecs.push_back('{3'b000, 2'd0, 32'h8000_0080, 32'hFFFF_FF80});
        vecs.push_back('{3'b101, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF});
        vecs.push_back('{3'b000, 2'd3, 32'hBEEF_1234, 32'hFFFF_FFBE});
        vecs.push_back('{3'b100, 2'd3, 32'hBEEF_1234, 32'h0000_00BE});
        vecs.push_back('{3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001});
        vecs.push_back('{3'b001, 2'd3, 32'hBEEF_1234, 32'hFFFF_BEEF});
        vecs.push_back('{3'b101, 2'd1, 32'hBEEF_1234, 32'h0000_1234});
        vecs.push_back('{3'b010, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{3'b111, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D});
        vecs.push_back('{3'b100, 2'd1, 32'h0000_8000, 32'h0000_0080});
        vecs.push_back('{3'b000, 2'd2, 32'h007F_0000, 32'h0000_007F});

        #1;
        cmp("reset", 5'd0, 32'd0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU write, then the pulse drops back to zero.
        do_alu("alu", 5'd5, 32'h1234_5678, 1'b0);
        drive(1'b0, '0, 1'b0, '0);
        check("alu_clear", 5'd0, 32'd0, 1'b1, 1'b0);

        // Table of load extensions with varied response delay.
        foreach (vecs[i]) begin
            drive(1'b1, mk(5'(i + 1), 32'h0, 1'b1, vecs[i].f3, vecs[i].off), 1'b0, '0);
            check($sformatf("vec%0d_acc", i), 5'd0, 32'd0, 1'b0, 1'b0);
            for (int k = 0; k < i % 3; k++) begin
                drive(1'b0, '0, 1'b0, '0);
                check($sformatf("vec%0d_wait", i), 5'd0, 32'd0, 1'b0, 1'b0);
            end
            drive(1'b0, '0, 1'b1, vecs[i].rdata);
            check($sformatf("vec%0d", i), 5'(i + 1), vecs[i].exp_data, 1'b1, 1'b0);
        end

        // rvalid in the last allowed wait cycle wins; rd 0 load still consumes data.
        do_load("rv_last", 5'd7, 3'b010, 2'd0, int'(T) - 1, 32'h0BAD_F00D);
        do_load("rd0_load", 5'd0, 3'b000, 2'd1, 1, 32'h0000_FF00);

        // Timeout, then a stray late response is ignored.
        do_load("timeout", 5'd9, 3'b010, 2'd0, int'(T), 32'h0);
        drive(1'b0, '0, 1'b1, 32'h1111_1111);
        check("stray_after_to", 5'd0, 32'd0, 1'b1, 1'b1);

        // Reset in the middle of a load wait.
        drive(1'b1, mk(5'd4, 32'h0, 1'b1, 3'b010, 2'd0), 1'b0, '0);
        check("rst_acc", 5'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        mem_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        err_exp = 1'b0;
        cmp("rst_imm", 5'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 32'h2222_2222);
        check("rst_stray", 5'd0, 32'd0, 1'b1, 1'b0);

        // Throughput: three back-to-back ALU ops, then a load with a held successor.
        do_alu("tp0", 5'd1, 32'hA, 1'b0);
        do_alu("tp1", 5'd2, 32'hB, 1'b0);
        do_alu("tp2", 5'd3, 32'hC, 1'b0);
        drive(1'b1, mk(5'd8, 32'h0, 1'b1, 3'b100, 2'd0), 1'b0, '0);
        check("tp_ld_acc", 5'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, mk(5'd9, 32'h99, 1'b0, 3'b000, 2'd0), 1'b0, '0);
        check("tp_hold", 5'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, mk(5'd9, 32'h99, 1'b0, 3'b000, 2'd0), 1'b1, 32'h0000_00F5);
        check("tp_ld_wr", 5'd8, 32'h0000_00F5, 1'b1, 1'b0);
        drive(1'b1, mk(5'd9, 32'h99, 1'b0, 3'b000, 2'd0), 1'b0, '0);
        check("tp_held_wr", 5'd9, 32'h99, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, '0);
        check("tp_end", 5'd0, 32'd0, 1'b1, 1'b0);

        // Randomized transactions against the transaction-level model.
        for (int n = 0; n < 150; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                drive(1'b0, memory_signals'($urandom), 1'($urandom), $urandom);
                check("rnd_idle", 5'd0, 32'd0, 1'b1, err_exp);
            end else if (kind == 1) begin
                do_alu("rnd_alu", 5'($urandom), $urandom, 1'($urandom));
            end else begin
                do_load("rnd_load", 5'($urandom), 3'($urandom), 2'($urandom),
                        int'($urandom_range(0, T + 1)), $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
